// File: rtl/axi_rd_pkg.sv
// Shared encodings and constants for the AXI read-channel responder.
// The WRAP support macro is AXI_RD_WRAP_EN (see axi_rd_addr_gen).
package axi_rd_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int unsigned DATA_W = 64;

    // Largest legal arsize for a data bus of dw bits.
    function automatic int unsigned max_size(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

    localparam int unsigned MAX_SIZE = max_size(DATA_W);

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational burst legality check and next-beat address generator.
// WRAP bursts are supported only when AXI_RD_WRAP_EN is defined; otherwise
// every WRAP burst is reported illegal and the wrap-mask logic is absent.
module axi_rd_addr_gen
    import axi_rd_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
) (
    input  logic [AW-1:0] addr,
    input  logic [7:0]    len,
    input  logic [2:0]    size,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr,
    output logic          burst_legal
);

    localparam logic [2:0] SIZE_LIMIT = 3'(max_size(DW));

    logic [AW-1:0] step;
    assign step = AW'(1) << size;

`ifdef AXI_RD_WRAP_EN
    logic [AW-1:0] wrap_mask;
    logic          wrap_len_ok;
    logic          wrap_aligned;
    assign wrap_mask    = ((AW'(len) + AW'(1)) << size) - AW'(1);
    assign wrap_len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    assign wrap_aligned = (addr & (step - AW'(1))) == '0;
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    // Classify the burst and compute the address of the following beat.
    always_comb begin
        next_addr   = addr;
        burst_legal = 1'b0;
        case (burst)
            BURST_FIXED: begin
                next_addr   = addr;
                burst_legal = (size <= SIZE_LIMIT);
            end
            BURST_INCR: begin
                next_addr   = addr + step;
                burst_legal = (size <= SIZE_LIMIT);
            end
            BURST_WRAP: begin
`ifdef AXI_RD_WRAP_EN
                next_addr   = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
                burst_legal = (size <= SIZE_LIMIT) && wrap_len_ok && wrap_aligned;
`else
                next_addr   = addr;
                burst_legal = 1'b0;
`endif
            end
            default: begin
                next_addr   = addr;
                burst_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/axi_read_protocol.sv
// Slave-side AXI read responder (AR + R channels) with a local fetch port.
// One burst at a time; illegal bursts return arlen+1 SLVERR beats without
// fetching. WRAP support is controlled by the AXI_RD_WRAP_EN macro.
module axi_read_protocol
    import axi_rd_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
) (
    input  logic          axi_aclk,
    input  logic          axi_aresetn,
    input  logic [AW-1:0] axi_araddr,
    input  logic [7:0]    axi_arlen,
    input  logic [2:0]    axi_arsize,
    input  logic [1:0]    axi_arburst,
    input  logic          axi_arvalid,
    output logic          axi_arready,
    output logic [DW-1:0] axi_rdata,
    output logic [1:0]    axi_rresp,
    output logic          axi_rlast,
    output logic          axi_rvalid,
    input  logic          axi_rready,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_valid,
    input  logic [DW-1:0] rd_data,
    output logic          busy
);

    state_t        state, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic          err_q, err_d;

    logic          arready_d, rvalid_d, rlast_d, rd_req_d;
    logic [1:0]    rresp_d;
    logic [DW-1:0] rdata_d;
    logic [AW-1:0] rd_addr_d;

    // Single generator: legality is only needed on the incoming AR fields in
    // IDLE, next_addr only on the latched fields afterwards, so share one.
    logic          in_idle;
    logic [AW-1:0] gen_addr, gen_next;
    logic [7:0]    gen_len;
    logic [2:0]    gen_size;
    logic [1:0]    gen_burst;
    logic          gen_legal;

    assign in_idle   = (state == IDLE);
    assign gen_addr  = in_idle ? axi_araddr  : addr_q;
    assign gen_len   = in_idle ? axi_arlen   : len_q;
    assign gen_size  = in_idle ? axi_arsize  : size_q;
    assign gen_burst = in_idle ? axi_arburst : burst_q;
    assign busy      = !in_idle;

    axi_rd_addr_gen #(.AW(AW), .DW(DW)) u_addr_gen (
        .addr        (gen_addr),
        .len         (gen_len),
        .size        (gen_size),
        .burst       (gen_burst),
        .next_addr   (gen_next),
        .burst_legal (gen_legal)
    );

    // State, burst context and all registered outputs.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rlast   <= 1'b0;
            axi_rresp   <= RESP_OKAY;
            axi_rdata   <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            axi_arready <= arready_d;
            axi_rvalid  <= rvalid_d;
            axi_rlast   <= rlast_d;
            axi_rresp   <= rresp_d;
            axi_rdata   <= rdata_d;
            rd_req      <= rd_req_d;
            rd_addr     <= rd_addr_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        arready_d = axi_arready;
        rvalid_d  = axi_rvalid;
        rlast_d   = axi_rlast;
        rresp_d   = axi_rresp;
        rdata_d   = axi_rdata;
        rd_req_d  = rd_req;
        rd_addr_d = rd_addr;

        case (state)
            IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid && axi_arready) begin
                    arready_d = 1'b0;
                    addr_d    = axi_araddr;
                    len_d     = axi_arlen;
                    cnt_d     = axi_arlen;
                    size_d    = axi_arsize;
                    burst_d   = axi_arburst;
                    err_d     = !gen_legal;
                    if (gen_legal) begin
                        state_d   = FETCH;
                        rd_req_d  = 1'b1;
                        rd_addr_d = axi_araddr;
                    end else begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = '0;
                        rlast_d  = (axi_arlen == 8'd0);
                    end
                end
            end
            FETCH: begin
                if (rd_valid) begin
                    state_d  = RESP;
                    rd_req_d = 1'b0;
                    rdata_d  = rd_data;
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q == 8'd0);
                end
            end
            RESP: begin
                if (axi_rvalid && axi_rready) begin
                    if (axi_rlast) begin
                        state_d   = IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = gen_next;
                        if (!err_q) begin
                            state_d   = FETCH;
                            rvalid_d  = 1'b0;
                            rd_req_d  = 1'b1;
                            rd_addr_d = gen_next;
                        end else begin
                            rvalid_d = 1'b1;
                            rlast_d  = (cnt_q == 8'd1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_protocol.sv
// Self-checking bench for axi_read_protocol. Expectations come from a
// burst-level model (address sequence, legality, per-beat response) that is
// adjusted to the AXI_RD_WRAP_EN setting used for the build.
module tb_axi_read_protocol;

`ifdef AXI_RD_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_valid = 1'b0;
    logic [63:0] rd_data;
    logic        busy;

    axi_read_protocol #(.AW(32), .DW(64)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .axi_araddr  (araddr),
        .axi_arlen   (arlen),
        .axi_arsize  (arsize),
        .axi_arburst (arburst),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rlast   (rlast),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_fetch[$];
    logic [31:0] fetch_log[$];

    // Local data source: contents are a fixed function of the address.
    function automatic logic [63:0] src_data(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a + 32'h1234_5678};
    endfunction
    assign rd_data = src_data(rd_addr);

    function automatic bit model_legal(input logic [31:0] a, input int len, input int size, input int burst);
        longint unsigned bytes;
        if (burst == 3 || size > 3) return 1'b0;
        if (burst == 2) begin
            bytes = 64'd1 << size;
            if (!WRAP_EN) return 1'b0;
            if (!((len + 1) inside {2, 4, 8, 16})) return 1'b0;
            if ((longint'(a) % bytes) != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] a, input int len, input int size, input int burst);
        longint unsigned bytes, total, base, av;
        av    = a;
        bytes = 64'd1 << size;
        total = bytes * longint'(len + 1);
        case (burst)
            1: return 32'(av + bytes);
            2: begin
                base = av - (av % total);
                return 32'(base + ((av - base + bytes) % total));
            end
            default: return a;
        endcase
    endfunction

    task automatic model_push(input logic [31:0] a0, input int len, input int size, input int burst);
        logic [31:0] a;
        beat_t       b;
        bit          ok;
        a  = a0;
        ok = model_legal(a0, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            b.last = (i == len);
            if (ok) begin
                exp_fetch.push_back(a);
                b.data = src_data(a);
                b.resp = 2'b00;
            end else begin
                b.data = '0;
                b.resp = 2'b10;
            end
            exp_beats.push_back(b);
            a = model_next(a, len, size, burst);
        end
    endtask

    // Fetch-latency and rready stall controls, plus per-burst position.
    int wait_cnt = 0;
    int delay_fetch = -1;
    int delay_amt = 0;
    int stall_beat = -1;
    int stall_left = 0;
    int beat_in_burst = 0;
    int fetch_in_burst = 0;

    // Drives rd_valid and rready just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rd_req) wait_cnt++;
        else        wait_cnt = 0;
        rd_valid = rd_req && (wait_cnt > ((fetch_in_burst == delay_fetch) ? delay_amt : 0));
        if (rvalid && beat_in_burst == stall_beat && stall_left > 0) begin
            rready = 1'b0;
            stall_left--;
        end else begin
            rready = 1'b1;
        end
    end

    // Compare process: runs on every falling edge against the model queues.
    logic        stalled_prev = 1'b0;
    logic [63:0] prev_rdata;
    logic [1:0]  prev_rresp;
    logic        prev_rlast;
    logic        fetch_wait_prev = 1'b0;
    logic [31:0] prev_rd_addr;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_beats.delete();
            exp_fetch.delete();
            beat_in_burst   = 0;
            fetch_in_burst  = 0;
            stalled_prev    = 1'b0;
            fetch_wait_prev = 1'b0;
        end else begin
            if (arvalid && arready) begin
                model_push(araddr, int'(arlen), int'(arsize), int'(arburst));
                beat_in_burst  = 0;
                fetch_in_burst = 0;
            end
            if (busy)   chk("arready_low_while_busy", arready, 0);
            if (rvalid) chk("no_rd_req_while_rvalid", rd_req, 0);
            if (stalled_prev) begin
                chk("stall_rvalid", rvalid, 1);
                chk("stall_rdata", rdata, prev_rdata);
                chk("stall_rresp", rresp, prev_rresp);
                chk("stall_rlast", rlast, prev_rlast);
            end
            if (fetch_wait_prev) begin
                chk("fetch_wait_rd_req", rd_req, 1);
                chk("fetch_wait_rd_addr", rd_addr, prev_rd_addr);
            end
            if (rd_req) begin
                chk("rd_req_expected", exp_fetch.size() != 0, 1);
                if (rd_valid && exp_fetch.size() != 0) begin
                    chk("rd_addr", rd_addr, exp_fetch.pop_front());
                    fetch_log.push_back(rd_addr);
                    fetch_in_burst++;
                end
            end
            if (rvalid && rready) begin
                chk("beat_expected", exp_beats.size() == 0, 0);
                if (exp_beats.size() != 0) begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    chk("rdata", rdata, b.data);
                    chk("rresp", rresp, b.resp);
                    chk("rlast", rlast, b.last);
                    beat_in_burst = b.last ? 0 : beat_in_burst + 1;
                end
            end
            stalled_prev    = rvalid && !rready;
            prev_rdata      = rdata;
            prev_rresp      = rresp;
            prev_rlast      = rlast;
            fetch_wait_prev = rd_req && !rd_valid;
            prev_rd_addr    = rd_addr;
        end
    end

    task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        araddr  = a;
        arlen   = l;
        arsize  = s;
        arburst = b;
        arvalid = 1'b1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 1000);
        chk("ar_accepted_in_time", arready, 1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        @(posedge clk);
        #1;
        set_ar(a, l, s, b);
        wait_accept();
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || exp_beats.size() != 0 || exp_fetch.size() != 0) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("burst_done_in_time", n < 2000, 1);
    endtask

    task automatic check_log(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3, input int n);
        logic [31:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_count"}, fetch_log.size(), n);
        for (int i = 0; i < n && i < fetch_log.size(); i++)
            chk(name, fetch_log[i], e[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arready_before_first_edge", arready, 0);
        @(negedge clk);
        chk("arready_after_first_edge", arready, 1);

        // INCR, 4 beats of 8 bytes
        fetch_log.delete();
        issue(32'h1000, 8'd3, 3'd3, 2'b01);
        wait_done();
        check_log("incr_addr", 32'h1000, 32'h1008, 32'h1010, 32'h1018, 4);
        chk("arready_after_incr", arready, 1);

        // WRAP, 4 beats, start mid-window
        fetch_log.delete();
        issue(32'h1018, 8'd3, 3'd3, 2'b10);
        wait_done();
        if (WRAP_EN) check_log("wrap_addr", 32'h1018, 32'h1000, 32'h1008, 32'h1010, 4);
        else         chk("wrap_disabled_no_fetch", fetch_log.size(), 0);

        // Single-beat INCR and 3-beat FIXED
        fetch_log.delete();
        issue(32'h40, 8'd0, 3'd3, 2'b01);
        wait_done();
        check_log("single_addr", 32'h40, 32'h0, 32'h0, 32'h0, 1);
        fetch_log.delete();
        issue(32'h20, 8'd2, 3'd2, 2'b00);
        wait_done();
        check_log("fixed_addr", 32'h20, 32'h20, 32'h20, 32'h0, 3);

        // Backpressure on beat 2, slow fetch on beat 3, next AR held pending
        stall_beat  = 1;
        stall_left  = 5;
        delay_fetch = 2;
        delay_amt   = 3;
        @(posedge clk);
        #1;
        set_ar(32'h2000, 8'd3, 3'd3, 2'b01);
        wait_accept();
        @(posedge clk);
        #1;
        set_ar(32'h3000, 8'd0, 3'd2, 2'b01);
        wait_accept();
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        wait_done();
        chk("stall_fully_consumed", stall_left, 0);
        stall_beat  = -1;
        delay_fetch = -1;

        // Illegal size, reserved burst, illegal WRAP variants
        fetch_log.delete();
        issue(32'h100, 8'd1, 3'd4, 2'b01);
        wait_done();
        issue(32'h200, 8'd1, 3'd2, 2'b11);
        wait_done();
        issue(32'h1004, 8'd3, 3'd3, 2'b10);
        wait_done();
        issue(32'h1000, 8'd2, 3'd3, 2'b10);
        wait_done();
        chk("illegal_no_fetch", fetch_log.size(), 0);

        // Longest burst: counter must run through 256 beats
        fetch_log.delete();
        issue(32'h8000, 8'd255, 3'd2, 2'b01);
        wait_done();
        chk("long_burst_fetches", fetch_log.size(), 256);
        if (fetch_log.size() == 256) chk("long_burst_last_addr", fetch_log[255], 32'h83FC);

        // Asynchronous reset while beat 2 of 4 is being presented
        @(posedge clk);
        #1;
        set_ar(32'h5000, 8'd3, 3'd3, 2'b01);
        wait_accept();
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk);
                #2;
                n++;
            end while (!(beat_in_burst == 1 && rvalid) && n < 100);
            chk("reached_beat2", beat_in_burst == 1 && rvalid, 1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rd_req", rd_req, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_arready_before_edge", arready, 0);
        @(negedge clk);
        chk("post_rst_arready", arready, 1);
        fetch_log.delete();
        issue(32'h6000, 8'd1, 3'd3, 2'b01);
        wait_done();
        check_log("post_rst_addr", 32'h6000, 32'h6008, 32'h0, 32'h0, 2);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_read_protocol.md
Name: axi_read_protocol

Overview:
- Slave-side AXI read-channel responder (AR + R). It is the read counterpart of the write-channel protocol FSM.
- Accepts one read burst at a time on AR and registers addr/len/size/burst.
- Generates per-beat addresses (FIXED/INCR, optionally WRAP) and fetches each beat from a simple local data source.
- Returns R beats with correct rlast/rresp, honouring rready backpressure.

Parameters:
- AW, 32, address width.
- DW, 64, data width; max legal arsize = log2(DW/8) = 3.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- axi_araddr  in  AW  burst start address.
- axi_arlen  in  8  beats minus one.
- axi_arsize  in  3  log2 bytes per beat.
- axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- axi_arvalid  in  1  address valid.
- axi_arready  out  1  address accepted.
- axi_rdata  out  DW  read data.
- axi_rresp  out  2  00 OKAY, 10 SLVERR.
- axi_rlast  out  1  final beat of burst.
- axi_rvalid  out  1  R beat valid.
- axi_rready  in  1  master accepts beat.
- rd_req  out  1  local fetch request, held until rd_valid.
- rd_addr  out  AW  beat address for fetch.
- rd_valid  in  1  fetch data valid (same cycle as rd_req or later).
- rd_data  in  DW  fetched data.
- busy  out  1  burst in progress (state != IDLE).

Behaviour:
- Reset (axi_aresetn=0, asynchronous):
  - Outputs: arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, rd_req=0, rd_addr=0, busy=0.
  - State: IDLE, beat counter=0.
  - arready rises on the first clock edge after reset release.
- Registered FSM, states IDLE, FETCH, RESP. All outputs are registered.
- IDLE:
  - arready=1.
  - On arvalid&&arready: latch fields, cnt<=arlen, arready<=0.
  - Legal burst: go to FETCH, rd_req=1, rd_addr=araddr on the next cycle (1-cycle AR-to-fetch latency).
  - Illegal burst: go to RESP with rresp=10, rdata=0. No fetch is ever issued for the burst.
- FETCH:
  - rd_req held high, rd_addr held stable.
  - On rd_valid: rd_req<=0, rdata<=rd_data, rresp<=00, rvalid<=1, rlast<=(cnt==0), go to RESP.
  - rd_valid outside FETCH is ignored.
- RESP:
  - rvalid, rdata, rresp and rlast are held stable while !rready.
  - On rvalid&&rready with rlast: rvalid<=0, rlast<=0, arready<=1, go to IDLE.
  - On rvalid&&rready without rlast: cnt<=cnt-1, addr<=next_addr.
    - Legal burst: go to FETCH.
    - Error burst: stay in RESP, next SLVERR beat presented next cycle, rlast set when cnt reaches 0.
- Illegal bursts (always return arlen+1 beats):
  - arburst=11.
  - arsize>3.
  - WRAP bursts, in either of these cases:
    - arlen+1 not in {2,4,8,16}, or araddr not aligned to the transfer size (macro enabled);
    - always (macro disabled).
- Next-address arithmetic (modulo 2^AW, no 4KB-crossing check):
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+(1<<size)) & mask).
- arlen=0: a single beat with rlast=1.
- arlen=255: the 8-bit counter must not wrap before rlast.
- Throughput: at most one beat per 2 cycles. rd_valid combinational with rd_req plus rready=1 gives a 2-cycle beat period.
- Reset mid-burst: everything is abandoned immediately, with no partial R beats after release. The data source must tolerate a dropped rd_req.

Optional Feature:
- AXI_RD_WRAP_EN defined: WRAP bursts are supported per the rules above.
- AXI_RD_WRAP_EN undefined: every WRAP burst returns arlen+1 SLVERR beats with rdata=0 and no rd_req. Wrap-mask logic is removed.

Decomposition:
- Package axi_rd_pkg:
  - burst encodings: BURST_FIXED/INCR/WRAP;
  - resp encodings: RESP_OKAY/SLVERR;
  - state enum: IDLE/FETCH/RESP;
  - constant MAX_SIZE derived from DW.
- Sub-module axi_rd_addr_gen: combinational. Inputs addr/len/size/burst; outputs next_addr and burst_legal. It is instanced once, and its WRAP path is gated by the macro.

Test Plan:
1. INCR araddr=0x1000, arlen=3, arsize=3, rready=1, rd_valid tied to rd_req -> rd_addr 0x1000, 0x1008, 0x1010, 0x1018; 4 OKAY beats; rdata=rd_data; rlast only on beat 4; arready back to 1 after beat 4.
2. WRAP araddr=0x1018, arlen=3, arsize=3 -> with macro: rd_addr 0x1018, 0x1000, 0x1008, 0x1010, rlast on 4th. Without macro: 4 SLVERR beats, rdata=0, rd_req never asserted.
3. INCR arlen=0 at 0x40, and FIXED arlen=2 at 0x20:
   - INCR case: single beat with rlast=1.
   - FIXED case: rd_addr 0x20 three times, rlast on 3rd.
4. Backpressure: hold rready=0 for 5 cycles on beat 2 of an INCR arlen=3 burst, and delay rd_valid by 3 cycles on beat 3 -> rdata/rlast/rresp stable, no new rd_req while stalled, rd_addr stable during the fetch wait, arvalid held high not accepted (arready=0).
5. Illegal arsize=4 and arburst=11, each with arlen=1 -> 2 SLVERR beats, rdata=0, no rd_req, rlast on beat 2.
6. Assert axi_aresetn=0 asynchronously between clock edges mid-burst (beat 2 of 4) -> rvalid, rd_req and busy drop immediately. After release, arready=1 one cycle later; a new INCR burst completes correctly.
